// File: rtl/imem_responder_if.sv
// Host-loader and fetch-stage signal bundle for the instruction-memory responder.
// The slave modport is the responder side; the master modport is the host/core side.
interface imem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [15:0]     fetch_addr;
    logic [15:0]     fetch_data;
    logic            core_en;
    logic            load_start;
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            load_ready;
    logic [ADDR_W:0] load_count;

    modport slave (
        input  fetch_addr,
        input  load_start,
        input  load_valid,
        input  load_byte,
        input  load_last,
        output fetch_data,
        output core_en,
        output load_ready,
        output load_count
    );

    modport master (
        output fetch_addr,
        output load_start,
        output load_valid,
        output load_byte,
        output load_last,
        input  fetch_data,
        input  core_en,
        input  load_ready,
        input  load_count
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: packs a host byte stream into 16-bit words in a
// synchronous RAM, then serves fetch addresses with one clock of latency.
module imem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_responder_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_LO = 2'd1,
        S_LOAD_HI = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        lo_q, lo_d;
    logic              core_en_q, core_en_d;
    logic [15:0]       fetch_q;
    logic              we_s;
    logic [15:0]       wdata_s;
    logic [ADDR_W-1:0] waddr_s;
    logic              hi_zero_s;
    logic              rd_en_s;

    logic [15:0] mem [DEPTH];

    // Addresses with any bit set above the RAM depth read back as zero.
    generate
        if (ADDR_W < 16) begin : g_hi_chk
            assign hi_zero_s = ~|bus.fetch_addr[15:ADDR_W];
        end else begin : g_hi_full
            assign hi_zero_s = 1'b1;
        end
    endgenerate

    assign rd_en_s        = (state_q == S_RUN) && hi_zero_s;
    assign waddr_s        = count_q[ADDR_W-1:0];
    assign bus.fetch_data = fetch_q;
    assign bus.core_en    = core_en_q;
    assign bus.load_count = count_q;
    assign bus.load_ready = (state_q == S_LOAD_LO) || (state_q == S_LOAD_HI);

    // Next-state, byte packing and RAM write control; load_start overrides everything.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lo_d      = lo_q;
        we_s      = 1'b0;
        wdata_s   = 16'h0000;
        core_en_d = 1'b0;
        if (bus.load_start) begin
            state_d   = S_LOAD_LO;
            count_d   = '0;
            core_en_d = 1'b0;
        end else begin
            core_en_d = (state_q == S_RUN);
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD_LO: begin
                    if (bus.load_valid) begin
                        lo_d = bus.load_byte;
                        if (bus.load_last) begin
                            we_s    = 1'b1;
                            wdata_s = {8'h00, bus.load_byte};
                            count_d = count_q + ONE_CNT;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_LOAD_HI;
                        end
                    end else begin
                        state_d = S_LOAD_LO;
                    end
                end
                S_LOAD_HI: begin
                    if (bus.load_valid) begin
                        we_s    = 1'b1;
                        wdata_s = {bus.load_byte, lo_q};
                        count_d = count_q + ONE_CNT;
                        if (bus.load_last || (count_q == LAST_WORD)) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_LOAD_LO;
                        end
                    end else begin
                        state_d = S_LOAD_HI;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            lo_q      <= 8'h00;
            core_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            core_en_q <= core_en_d;
        end
    end

    // Single write port; RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Registered read port; zero outside RUN or for out-of-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= 16'h0000;
        end else if (rd_en_s) begin
            fetch_q <= mem[bus.fetch_addr[ADDR_W-1:0]];
        end else begin
            fetch_q <= 16'h0000;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a vector table for ADDR_W=8 plus
// hand sequences for async reset during a load and the full-memory stop at ADDR_W=2.
module tb_imem_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imem_responder_if #(.ADDR_W(8)) bus8 ();
    imem_responder_if #(.ADDR_W(2)) bus2 ();

    imem_responder #(.ADDR_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    imem_responder #(.ADDR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [7:0]  data_b;
        logic [15:0] addr;
        logic [15:0] exp_data;
        logic        exp_en;
        logic        exp_rdy;
        logic [8:0]  exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic s, input logic v, input logic l,
                                input logic [7:0] b, input logic [15:0] a,
                                input logic [15:0] d, input logic e,
                                input logic r, input logic [8:0] c);
        vec_t t;
        t = '{start: s, valid: v, last: l, data_b: b, addr: a,
              exp_data: d, exp_en: e, exp_rdy: r, exp_cnt: c};
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic chk8(input int idx, input logic [15:0] d, input logic e,
                        input logic r, input logic [8:0] c);
        chk("fetch_data", idx, bus8.fetch_data, d);
        chk("core_en", idx, {15'h0000, bus8.core_en}, {15'h0000, e});
        chk("load_ready", idx, {15'h0000, bus8.load_ready}, {15'h0000, r});
        chk("load_count", idx, {7'h00, bus8.load_count}, {7'h00, c});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus8.load_start = 1'b0; bus8.load_valid = 1'b0; bus8.load_last = 1'b0;
        bus8.load_byte  = 8'h00; bus8.fetch_addr = 16'h0000;
        bus2.load_start = 1'b0; bus2.load_valid = 1'b0; bus2.load_last = 1'b0;
        bus2.load_byte  = 8'h00; bus2.fetch_addr = 16'h0000;

        //          s     v     l     byte   addr      data      en    rdy   cnt
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h34, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h78, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h56, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd2));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'hBC, 16'h0000, 16'h0000, 1'b0, 1'b1, 9'd2));
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 8'h9A, 16'h0000, 16'h0000, 1'b0, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1234, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0001, 16'h5678, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0002, 16'h9ABC, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1234, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0100, 16'h0000, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234, 1'b1, 1'b0, 9'd3));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 8'h55, 16'h0001, 16'h5678, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h11, 16'h0001, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h22, 16'h0001, 16'h0000, 1'b0, 1'b1, 9'd1));
        vq.push_back(mk(1'b0, 1'b1, 1'b1, 8'h33, 16'h0001, 16'h0000, 1'b0, 1'b0, 9'd2));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0001, 16'h0033, 1'b1, 1'b0, 9'd2));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h2211, 1'b1, 1'b0, 9'd2));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 16'h0002, 16'h9ABC, 1'b1, 1'b0, 9'd2));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0002, 16'h9ABC, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h44, 16'h0002, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 8'h66, 16'h0002, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h77, 16'h0002, 16'h0000, 1'b0, 1'b1, 9'd0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h88, 16'h0002, 16'h0000, 1'b0, 1'b1, 9'd1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h99, 16'h0002, 16'h0000, 1'b0, 1'b1, 9'd1));

        #3;
        chk8(-1, 16'h0000, 1'b0, 1'b0, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            bus8.load_start = vq[i].start;
            bus8.load_valid = vq[i].valid;
            bus8.load_last  = vq[i].last;
            bus8.load_byte  = vq[i].data_b;
            bus8.fetch_addr = vq[i].addr;
            @(posedge clk);
            #1;
            chk8(i, vq[i].exp_data, vq[i].exp_en, vq[i].exp_rdy, vq[i].exp_cnt);
        end

        // Asynchronous reset while sitting in LOAD_HI, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk8(100, 16'h0000, 1'b0, 1'b0, 9'd0);
        bus8.load_start = 1'b0;
        bus8.load_valid = 1'b1;
        bus8.load_byte  = 8'hAA;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk8(101, 16'h0000, 1'b0, 1'b0, 9'd0);
        bus8.load_valid = 1'b0;

        // ADDR_W=2: ten bytes with no load_last; memory fills after the eighth.
        bus2.load_start = 1'b1;
        @(posedge clk);
        #1;
        bus2.load_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus2.load_valid = 1'b1;
            bus2.load_byte  = 8'(k);
            bus2.fetch_addr = 16'h0000;
            @(posedge clk);
            #1;
            chk("a2_count", k, {13'h0000, bus2.load_count}, 16'(k >= 8 ? 4 : k / 2));
            chk("a2_ready", k, {15'h0000, bus2.load_ready}, {15'h0000, (k < 8)});
            chk("a2_core_en", k, {15'h0000, bus2.core_en}, {15'h0000, (k >= 9)});
        end
        bus2.load_valid = 1'b0;
        for (int a = 0; a < 6; a++) begin
            logic [15:0] exp_w;
            bus2.fetch_addr = 16'(a);
            exp_w = (a < 4) ? {8'(2 * a + 2), 8'(2 * a + 1)} : 16'h0000;
            @(posedge clk);
            #1;
            chk("a2_fetch", a, bus2.fetch_data, exp_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
